dram_read_scatter: RTL and testbench
====================================

// Module: dram_read_scatter
// PURPOSE
//  Read-side counterpart of the DRAM write collector. Accepts one warp of per-lane global
//  addresses and valid bits from the AccumWarpLooper and coalesces them into cache-line
//  DRAM read requests. It scatters each returned line into the lanes that hit it, then
//  emits the complete warp of data to the ALU-side consumer. Sits in the read pipeline
//  between the warp looper and the DRAM read port.
// PARAMETERS
//  VSIZE  TauCfg::VSIZE           lanes per warp
//  CSIZE  TauCfg::CACHE_SIZE      data words per DRAM line
//  GBW    TauCfg::GLOBAL_ADDR_BW  global word-address width
//  DBW    TauCfg::DATA_BW         data word width
// PORTS
//  i_clk          in   1             clock
//  i_rst          in   1             async reset, active-low
//  addrval_rdy    in   1             warp address bundle valid
//  addrval_ack    out  1             bundle accepted (1-cycle pulse)
//  i_address      in   GBW x VSIZE   per-lane word address
//  i_valid        in   VSIZE         per-lane enable
//  dramra_rdy     out  1             line read request valid
//  dramra_ack     in   1             request taken
//  o_dramra       out  GBW           line-aligned word address (low log2(CSIZE) bits zero)
//  dramrd_rdy     in   1             read line valid
//  dramrd_ack     out  1             read line consumed (1-cycle pulse)
//  i_dramrd       in   DBW x CSIZE   returned line
//  warp_dat_rdy   out  1             warp data valid
//  warp_dat_ack   in   1             warp data taken
//  o_warp_dat     out  DBW x VSIZE   per-lane data
//  o_warp_valid   out  VSIZE         copy of the latched i_valid
// BEHAVIOUR
//  - Handshake rule: a transfer occurs in the cycle where rdy & ack are both 1. A sender
//    holds rdy and its data stable until that cycle. All acks are registered.
//  - Reset values: all rdy/ack outputs 0, o_dramra 0, o_warp_dat all 0, o_warp_valid 0,
//    FSM in IDLE, pending mask 0.
//  - FSM IDLE -> REQ -> WAIT -> (REQ | OUT) -> IDLE:
//    IDLE: on addrval_rdy, latch addresses, set pending = i_valid and o_warp_valid = i_valid,
//      clear lane data to 0, and pulse addrval_ack. If i_valid == 0, go to OUT;
//      otherwise go to REQ.
//    REQ: leader = lowest-index pending lane (priority finder).
//      o_dramra = addr[leader] with the low OFS_BW bits cleared; dramra_rdy = 1.
//      On dramra_ack, go to WAIT. The leader line is registered at REQ entry.
//    WAIT: when dramrd_rdy, pulse dramrd_ack. For every pending lane whose line tag equals
//      the leader tag: dat[lane] <= i_dramrd[addr[lane][OFS_BW-1:0]]; clear its pending bit.
//      If any pending bit remains, go to REQ; otherwise go to OUT.
//    OUT: warp_dat_rdy = 1 until warp_dat_ack, then go to IDLE. addrval is not accepted
//      while in OUT.
//  - Only one DRAM read is outstanding at a time. dramrd_ack is never asserted outside WAIT,
//    so a stray line is held off rather than dropped.
//  - Line tag = addr[GBW-1:OFS_BW], with OFS_BW = $clog2(CSIZE). Lanes that are invalid
//    output 0 and never generate a request.
//  - Duplicate addresses in several lanes are served by one request. N distinct lines need
//    exactly N requests, issued in ascending leader-lane order.
//  - Latency for one line: IDLE -> REQ 1 cycle, plus DRAM round trip, plus 1 cycle to OUT.
//  - Reset mid-operation clears all state immediately. Any in-flight DRAM response is the
//    responsibility of the DRAM model to flush.
// STRUCTURE
//  - Add OFS_BW and line-tag width to the TauCfg package so the write collector and this
//    block share the same definitions.
//  - Sub-module find_first_lane: combinational lowest-set-bit finder over VSIZE.
//    Outputs index (CV_BW) and a found flag.
//  - The remainder of the block is a single FSM plus lane registers. VSIZE parallel tag
//    comparators and CSIZE:1 muxes are generated with for-generate loops.
// TESTING
//  1. VSIZE=32, CSIZE=32; lane i addr = 0x100+i, all valid -> one dramra 0x100.
//     Line word k = k -> o_warp_dat[i] = i, one read.
//  2. Lanes split across lines 0x100/0x140/0x180 (interleaved), all valid -> requests
//     0x100, 0x140, 0x180 in leader order; data correct per lane.
//  3. i_valid = 0 -> no dramra_rdy; warp_dat_rdy 2 cycles after addrval_ack; data 0,
//     valid 0.
//  4. Backpressure: hold dramra_ack, dramrd_rdy and warp_dat_ack low for 10 cycles each
//     -> outputs stable, no duplicate requests, and no extra acks.
//  5. Assert reset in WAIT with 3 lines pending -> all outputs return to reset values.
//     The next warp is processed correctly.
//  6. Only lane 31 valid, addr 0x1FF -> dramra 0x1E0; o_warp_dat[31] = line word 31;
//     others 0.

Source files
------------

// File: rtl/dram_read_scatter_pkg.sv
// Shared read/write collector configuration: warp geometry, DRAM line geometry and
// the derived line offset / tag widths used by both collectors.
package dram_read_scatter_pkg;
   localparam int CFG_VSIZE  = 32;
   localparam int CFG_CSIZE  = 32;
   localparam int CFG_GBW    = 16;
   localparam int CFG_DBW    = 32;
   localparam int CFG_OFS_BW = $clog2(CFG_CSIZE);
   localparam int CFG_TAG_BW = CFG_GBW - CFG_OFS_BW;
   localparam int CFG_CV_BW  = $clog2(CFG_VSIZE);
endpackage

// File: rtl/dram_read_scatter_if.sv
// Bundle of the three handshaked channels around the read scatter: warp addresses in,
// DRAM line request/response, and warp data out.
interface dram_read_scatter_if
   import dram_read_scatter_pkg::*;
#(
   parameter int VSIZE = CFG_VSIZE,
   parameter int CSIZE = CFG_CSIZE,
   parameter int GBW   = CFG_GBW,
   parameter int DBW   = CFG_DBW
);
   logic                       addrval_rdy;
   logic                       addrval_ack;
   logic [VSIZE-1:0][GBW-1:0]  i_address;
   logic [VSIZE-1:0]           i_valid;
   logic                       dramra_rdy;
   logic                       dramra_ack;
   logic [GBW-1:0]             o_dramra;
   logic                       dramrd_rdy;
   logic                       dramrd_ack;
   logic [CSIZE-1:0][DBW-1:0]  i_dramrd;
   logic                       warp_dat_rdy;
   logic                       warp_dat_ack;
   logic [VSIZE-1:0][DBW-1:0]  o_warp_dat;
   logic [VSIZE-1:0]           o_warp_valid;

   modport slave (
      input  addrval_rdy, i_address, i_valid, dramra_ack, dramrd_rdy, i_dramrd, warp_dat_ack,
      output addrval_ack, dramra_rdy, o_dramra, dramrd_ack, warp_dat_rdy, o_warp_dat, o_warp_valid
   );

   modport master (
      output addrval_rdy, i_address, i_valid, dramra_ack, dramrd_rdy, i_dramrd, warp_dat_ack,
      input  addrval_ack, dramra_rdy, o_dramra, dramrd_ack, warp_dat_rdy, o_warp_dat, o_warp_valid
   );
endinterface

// File: rtl/dram_read_scatter_find_first_lane.sv
// Combinational lowest-set-bit finder: picks the leader lane among the pending lanes.
module find_first_lane
   import dram_read_scatter_pkg::*;
#(
   parameter int VSIZE = CFG_VSIZE,
   parameter int CV_BW = CFG_CV_BW
) (
   input  logic [VSIZE-1:0] vec,
   output logic [CV_BW-1:0] idx,
   output logic             found
);
   // Scan downwards so the last assignment wins with the lowest index.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = VSIZE - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = CV_BW'(i);
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/dram_read_scatter.sv
// Coalesces a warp of lane addresses into one DRAM line read per distinct line, scatters
// each returned line into every lane that hits it, then hands the full warp downstream.
module dram_read_scatter
   import dram_read_scatter_pkg::*;
#(
   parameter int VSIZE = CFG_VSIZE,
   parameter int CSIZE = CFG_CSIZE,
   parameter int GBW   = CFG_GBW,
   parameter int DBW   = CFG_DBW
) (
   input  logic               i_clk,
   input  logic               i_rst,
   dram_read_scatter_if.slave io
);
   localparam int OFS_BW = $clog2(CSIZE);
   localparam int TAG_BW = GBW - OFS_BW;
   localparam int CV_BW  = (VSIZE > 1) ? $clog2(VSIZE) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] OUT  = 2'd3;

   logic [1:0]        state;
   logic [GBW-1:0]    addr_q [VSIZE];
   logic [VSIZE-1:0]  pending;
   logic [TAG_BW-1:0] lead_tag;
   logic [VSIZE-1:0]  hit;
   logic [VSIZE-1:0]  scan_vec;
   logic [CV_BW-1:0]  lead_idx;
   logic              lead_found;
   logic [GBW-1:0]    lead_addr;
   logic [DBW-1:0]    line_word [VSIZE];

   function automatic logic [GBW-1:0] line_base(input logic [GBW-1:0] a);
      return {a[GBW-1:OFS_BW], {OFS_BW{1'b0}}};
   endfunction

   for (genvar g = 0; g < VSIZE; g++) begin : g_lane
      assign hit[g]       = pending[g] && (addr_q[g][GBW-1:OFS_BW] == lead_tag);
      assign line_word[g] = io.i_dramrd[addr_q[g][OFS_BW-1:0]];
   end

   // The next leader is chosen from the lanes still pending after this cycle, so the
   // request for the following line can be registered in the same edge that leaves WAIT.
   always_comb begin
      scan_vec  = pending & ~hit;
      lead_addr = addr_q[lead_idx];
      if (state == IDLE) begin
         scan_vec  = io.i_valid;
         lead_addr = io.i_address[lead_idx];
      end
   end

   find_first_lane #(.VSIZE(VSIZE), .CV_BW(CV_BW)) u_find_first (
      .vec   (scan_vec),
      .idx   (lead_idx),
      .found (lead_found)
   );

   always_ff @(posedge i_clk) begin
      if (state == IDLE && io.addrval_rdy && !io.addrval_ack) begin
         for (int i = 0; i < VSIZE; i++) addr_q[i] <= io.i_address[i];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state           <= IDLE;
         pending         <= '0;
         lead_tag        <= '0;
         io.addrval_ack  <= 1'b0;
         io.dramra_rdy   <= 1'b0;
         io.o_dramra     <= '0;
         io.dramrd_ack   <= 1'b0;
         io.warp_dat_rdy <= 1'b0;
         io.o_warp_dat   <= '0;
         io.o_warp_valid <= '0;
      end else begin
         io.addrval_ack <= 1'b0;
         io.dramrd_ack  <= 1'b0;
         case (state)
            IDLE: begin
               if (io.addrval_rdy && !io.addrval_ack) begin
                  io.addrval_ack  <= 1'b1;
                  pending         <= io.i_valid;
                  io.o_warp_valid <= io.i_valid;
                  io.o_warp_dat   <= '0;
                  if (lead_found) begin
                     state         <= REQ;
                     io.dramra_rdy <= 1'b1;
                     io.o_dramra   <= line_base(lead_addr);
                     lead_tag      <= lead_addr[GBW-1:OFS_BW];
                  end else begin
                     state <= OUT;
                  end
               end
            end
            REQ: begin
               if (io.dramra_ack) begin
                  io.dramra_rdy <= 1'b0;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (io.dramrd_rdy) begin
                  io.dramrd_ack <= 1'b1;
                  pending       <= pending & ~hit;
                  for (int i = 0; i < VSIZE; i++) begin
                     if (hit[i]) io.o_warp_dat[i] <= line_word[i];
                  end
                  if (lead_found) begin
                     state         <= REQ;
                     io.dramra_rdy <= 1'b1;
                     io.o_dramra   <= line_base(lead_addr);
                     lead_tag      <= lead_addr[GBW-1:OFS_BW];
                  end else begin
                     state <= OUT;
                  end
               end
            end
            OUT: begin
               // Warp data is offered only once the address bundle handshake has retired.
               if (io.warp_dat_rdy && io.warp_dat_ack) begin
                  io.warp_dat_rdy <= 1'b0;
                  state           <= IDLE;
               end else if (!io.addrval_ack) begin
                  io.warp_dat_rdy <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dram_read_scatter.sv
// Scoreboard bench for dram_read_scatter: DRAM responder, warp consumer and a negedge
// monitor checking requests, warp data and handshake behaviour against queued expectations.
module tb_dram_read_scatter;
   import dram_read_scatter_pkg::*;

   localparam int VS = CFG_VSIZE;
   localparam int CS = CFG_CSIZE;
   localparam int AW = CFG_GBW;
   localparam int DW = CFG_DBW;

   typedef logic [VS-1:0][DW-1:0] warp_t;
   typedef logic [VS-1:0][AW-1:0] addrs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   dram_read_scatter_if io ();

   dram_read_scatter u_dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .io    (io)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [AW-1:0]   exp_req_q [$];
   warp_t           exp_dat_q [$];
   logic [VS-1:0]   exp_val_q [$];

   int   req_hs = 0, warp_hs = 0, addr_acks = 0, rd_acks = 0;
   int   ra_hold = 0, rd_delay = 2, dat_hold = 0;
   logic dram_flush = 1'b0;
   logic dram_busy  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] line_word(input logic [AW-1:0] base, input int k);
      return ((DW'(base) - DW'(32'h100)) << 8) | DW'(k);
   endfunction

   task automatic expect_warp(input addrs_t a, input logic [VS-1:0] v);
      warp_t d;
      d = '0;
      for (int i = 0; i < VS; i++) begin
         if (v[i]) d[i] = line_word(a[i] & ~AW'(CS - 1), int'(a[i] & AW'(CS - 1)));
      end
      exp_dat_q.push_back(d);
      exp_val_q.push_back(v);
   endtask

   // DRAM: one outstanding read, ack after ra_hold cycles, line back after rd_delay cycles.
   initial begin
      logic [AW-1:0] base;
      logic          got;
      io.dramra_ack = 1'b0;
      io.dramrd_rdy = 1'b0;
      io.i_dramrd   = '0;
      forever begin
         @(negedge clk);
         if (!dram_flush && io.dramra_rdy) begin
            dram_busy = 1'b1;
            for (int c = 0; c < ra_hold && !dram_flush; c++) @(negedge clk);
            if (!dram_flush) begin
               @(posedge clk); #1;
               io.dramra_ack = 1'b1;
               @(negedge clk);
               base = io.o_dramra;
               @(posedge clk); #1;
               io.dramra_ack = 1'b0;
               for (int c = 0; c < rd_delay && !dram_flush; c++) @(posedge clk);
               if (!dram_flush) begin
                  #1;
                  for (int k = 0; k < CS; k++) io.i_dramrd[k] = line_word(base, k);
                  io.dramrd_rdy = 1'b1;
                  got = 1'b0;
                  for (int c = 0; c < 100 && !got && !dram_flush; c++) begin
                     @(negedge clk);
                     got = io.dramrd_ack;
                  end
                  if (!dram_flush) check("dramrd_ack_timeout", {63'd0, got}, 64'd1);
                  @(posedge clk); #1;
               end
            end
            io.dramra_ack = 1'b0;
            io.dramrd_rdy = 1'b0;
            io.i_dramrd   = '0;
            dram_busy = 1'b0;
         end
      end
   end

   // Warp consumer with dat_hold cycles of backpressure.
   initial begin
      io.warp_dat_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && io.warp_dat_rdy) begin
            for (int c = 0; c < dat_hold; c++) @(negedge clk);
            @(posedge clk); #1;
            io.warp_dat_ack = 1'b1;
            @(posedge clk); #1;
            io.warp_dat_ack = 1'b0;
         end
      end
   end

   // Monitor: scoreboard pops plus hold-stability and stray-ack checks.
   initial begin
      logic          ra_wait, wd_wait;
      logic [AW-1:0] ra_prev;
      warp_t         wd_prev, ed;
      logic [VS-1:0] ev;
      int            bad;
      ra_wait = 1'b0;
      wd_wait = 1'b0;
      ra_prev = '0;
      wd_prev = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ra_wait = 1'b0;
            wd_wait = 1'b0;
         end else begin
            if (ra_wait) begin
               check("dramra_rdy_held", {63'd0, io.dramra_rdy}, 64'd1);
               check("o_dramra_stable", 64'(io.o_dramra), 64'(ra_prev));
            end
            if (wd_wait) begin
               check("warp_rdy_held", {63'd0, io.warp_dat_rdy}, 64'd1);
               check("warp_dat_stable", {63'd0, io.o_warp_dat == wd_prev}, 64'd1);
            end
            if (io.addrval_ack) addr_acks++;
            if (io.dramrd_ack) begin
               rd_acks++;
               check("dramrd_ack_needs_rdy", {63'd0, io.dramrd_rdy}, 64'd1);
            end
            if (io.dramra_rdy && io.dramra_ack) begin
               req_hs++;
               if (exp_req_q.size() == 0) check("dramra_unexpected", 64'(io.o_dramra), 64'hFFFF_FFFF);
               else check("dramra_addr", 64'(io.o_dramra), 64'(exp_req_q.pop_front()));
            end
            if (io.warp_dat_rdy && io.warp_dat_ack) begin
               warp_hs++;
               if (exp_dat_q.size() == 0) begin
                  check("warp_unexpected", 64'd1, 64'd0);
               end else begin
                  ed = exp_dat_q.pop_front();
                  ev = exp_val_q.pop_front();
                  check("warp_valid", 64'(io.o_warp_valid), 64'(ev));
                  bad = -1;
                  for (int i = VS - 1; i >= 0; i--) if (io.o_warp_dat[i] !== ed[i]) bad = i;
                  n_tests++;
                  if (bad >= 0) begin
                     n_fail++;
                     $display("[TB] FAIL warp_dat lane %0d: got 0x%0h expected 0x%0h",
                              bad, io.o_warp_dat[bad], ed[bad]);
                  end
               end
            end
            ra_wait = io.dramra_rdy && !io.dramra_ack;
            ra_prev = io.o_dramra;
            wd_wait = io.warp_dat_rdy && !io.warp_dat_ack;
            wd_prev = io.o_warp_dat;
         end
      end
   end

   task automatic send_warp(input addrs_t a, input logic [VS-1:0] v, output int ack_cyc,
                            output logic ra_at_ack);
      logic got;
      got = 1'b0;
      ack_cyc = 0;
      ra_at_ack = 1'b0;
      @(posedge clk); #1;
      io.i_address   = a;
      io.i_valid     = v;
      io.addrval_rdy = 1'b1;
      for (int c = 0; c < 50 && !got; c++) begin
         @(negedge clk);
         if (io.addrval_ack) begin
            got = 1'b1;
            ack_cyc = cyc;
            ra_at_ack = io.dramra_rdy;
         end
      end
      check("addrval_ack_timeout", {63'd0, got}, 64'd1);
      @(posedge clk); #1;
      io.addrval_rdy = 1'b0;
   endtask

   task automatic wait_done(input string name);
      logic done;
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         @(negedge clk);
         done = (exp_dat_q.size() == 0) && (exp_req_q.size() == 0) && !dram_busy &&
                !io.warp_dat_rdy && !io.warp_dat_ack;
      end
      check(name, {63'd0, done}, 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addrval_ack"}, {63'd0, io.addrval_ack}, 64'd0);
      check({tag, "_dramra_rdy"}, {63'd0, io.dramra_rdy}, 64'd0);
      check({tag, "_o_dramra"}, 64'(io.o_dramra), 64'd0);
      check({tag, "_dramrd_ack"}, {63'd0, io.dramrd_ack}, 64'd0);
      check({tag, "_warp_dat_rdy"}, {63'd0, io.warp_dat_rdy}, 64'd0);
      check({tag, "_o_warp_dat_zero"}, {63'd0, io.o_warp_dat == '0}, 64'd1);
      check({tag, "_o_warp_valid"}, 64'(io.o_warp_valid), 64'd0);
   endtask

   initial begin
      addrs_t        a;
      logic [AW-1:0] bases [3];
      int            ack_cyc, lat, r0, d0, w0, k0;
      logic          ra_at, seen;

      io.addrval_rdy = 1'b0;
      io.i_address   = '0;
      io.i_valid     = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Test 1: one line, lane i -> word i.
      for (int i = 0; i < VS; i++) a[i] = AW'(16'h100 + i);
      exp_req_q.push_back(16'h100);
      expect_warp(a, '1);
      r0 = req_hs; d0 = rd_acks; w0 = warp_hs; k0 = addr_acks;
      send_warp(a, '1, ack_cyc, ra_at);
      check("t1_req_with_ack", {63'd0, ra_at}, 64'd1);
      wait_done("t1_done");
      check("t1_reqs", 64'(req_hs - r0), 64'd1);
      check("t1_rd_acks", 64'(rd_acks - d0), 64'd1);
      check("t1_warps", 64'(warp_hs - w0), 64'd1);
      check("t1_addr_acks", 64'(addr_acks - k0), 64'd1);

      // Test 2: three interleaved lines, served in leader-lane order.
      bases[0] = 16'h100; bases[1] = 16'h140; bases[2] = 16'h180;
      for (int i = 0; i < VS; i++) a[i] = bases[i % 3] + AW'((i * 5 + 3) % CS);
      exp_req_q.push_back(16'h100);
      exp_req_q.push_back(16'h140);
      exp_req_q.push_back(16'h180);
      expect_warp(a, '1);
      r0 = req_hs; d0 = rd_acks;
      send_warp(a, '1, ack_cyc, ra_at);
      wait_done("t2_done");
      check("t2_reqs", 64'(req_hs - r0), 64'd3);
      check("t2_rd_acks", 64'(rd_acks - d0), 64'd3);

      // Test 3: no valid lanes, no DRAM traffic, data two cycles after the ack.
      expect_warp(a, '0);
      r0 = req_hs;
      send_warp(a, '0, ack_cyc, ra_at);
      seen = 1'b0;
      lat = -1;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (io.warp_dat_rdy) begin
            seen = 1'b1;
            lat = cyc - ack_cyc;
         end
      end
      check("t3_out_latency", 64'(lat), 64'd2);
      wait_done("t3_done");
      check("t3_reqs", 64'(req_hs - r0), 64'd0);

      // Test 4: ten cycles of backpressure on every channel, two lines.
      ra_hold = 10; rd_delay = 10; dat_hold = 10;
      for (int i = 0; i < VS; i++) a[i] = (i % 2 == 0) ? AW'(16'h200 + i) : AW'(16'h220 + i);
      exp_req_q.push_back(16'h200);
      exp_req_q.push_back(16'h220);
      expect_warp(a, '1);
      r0 = req_hs; d0 = rd_acks; w0 = warp_hs; k0 = addr_acks;
      send_warp(a, '1, ack_cyc, ra_at);
      wait_done("t4_done");
      check("t4_reqs", 64'(req_hs - r0), 64'd2);
      check("t4_rd_acks", 64'(rd_acks - d0), 64'd2);
      check("t4_warps", 64'(warp_hs - w0), 64'd1);
      check("t4_addr_acks", 64'(addr_acks - k0), 64'd1);
      ra_hold = 0; rd_delay = 40; dat_hold = 0;

      // Test 5: reset while waiting on the first of three lines.
      bases[0] = 16'h300; bases[1] = 16'h320; bases[2] = 16'h340;
      for (int i = 0; i < VS; i++) a[i] = bases[i % 3] + AW'(i);
      exp_req_q.push_back(16'h300);
      r0 = req_hs;
      send_warp(a, '1, ack_cyc, ra_at);
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         seen = (req_hs != r0);
      end
      check("t5_first_req", {63'd0, seen}, 64'd1);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      dram_flush = 1'b1;
      @(negedge clk);
      check_reset_outputs("t5");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         seen = !dram_busy;
      end
      check("t5_dram_flushed", {63'd0, seen}, 64'd1);
      dram_flush = 1'b0;
      rd_delay = 2;
      check("t5_reqs", 64'(req_hs - r0), 64'd1);

      // Test 6: only lane 31 valid at 0x1FF -> line 0x1E0, word 31.
      for (int i = 0; i < VS; i++) a[i] = AW'(16'h300 + i);
      a[VS-1] = 16'h1FF;
      exp_req_q.push_back(16'h1E0);
      expect_warp(a, {1'b1, {(VS - 1){1'b0}}});
      r0 = req_hs;
      send_warp(a, {1'b1, {(VS - 1){1'b0}}}, ack_cyc, ra_at);
      wait_done("t6_done");
      check("t6_reqs", 64'(req_hs - r0), 64'd1);
      check("t6_lane31_word", 64'(io.o_warp_dat[VS-1]), 64'h0000_E01F);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
